// File: rtl/div_iter_top_if.sv
// Operand/result handshake bundle for the iterative floating-point divider.
// The master side issues operands and consumes results; the slave side is the divider.
interface div_iter_top_if #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
);
    localparam int W = SIGN_W + EXPO_W + MANT_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   rnd;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic [4:0]   status;

    modport master (
        output in_valid, a, b, rnd, out_ready,
        input  in_ready, out_valid, res, status
    );

    modport slave (
        input  in_valid, a, b, rnd, out_ready,
        output in_ready, out_valid, res, status
    );
endinterface

// File: rtl/div_iter_top.sv
// Iterative IEEE-754 divider: radix-2 restoring mantissa divide, one quotient bit per cycle.
// Latency MANT_W+6 cycles from accept to out_valid; in_ready low while busy, result held until out_ready.
module div_iter_top #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic          clk,
    input  logic          rst,
    div_iter_top_if.slave bus
);
    localparam int W   = SIGN_W + EXPO_W + MANT_W;
    localparam int XW  = EXPO_W + 2;
    localparam int QW  = MANT_W + 3;
    localparam int LZW = $clog2(MANT_W + 2);
    localparam int CW  = $clog2(MANT_W + 3);
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXPO_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXPO_W) - 1);
    localparam logic [CW-1:0]        LAST = CW'(MANT_W + 2);

    typedef enum logic [2:0] {S_IDLE, S_NORM, S_DIV, S_ROUND, S_DONE} state_t;

    state_t                r_state;
    logic [W-1:0]          r_a, r_b, r_res, r_spec_res;
    logic [1:0]            r_rnd;
    logic                  r_sign, r_stk, r_phase, r_spec;
    logic signed [XW-1:0]  r_exp;
    logic [MANT_W+1:0]     r_rem;
    logic [MANT_W:0]       r_div;
    logic [QW-1:0]         r_q;
    logic [CW-1:0]         r_cnt;
    logic [4:0]            r_status, r_spec_st;
    logic                  r_in_ready, r_out_valid;

    function automatic logic [LZW-1:0] f_lzc(input logic [MANT_W:0] v);
        logic [LZW-1:0] n;
        logic           hit;
        n   = '0;
        hit = 1'b0;
        for (int i = MANT_W; i >= 0; i--) begin
            hit = hit | v[i];
            if (!hit) n = n + LZW'(1);
        end
        return n;
    endfunction

    // Operand classification and normalisation
    logic [EXPO_W-1:0]    w_ea, w_eb;
    logic [MANT_W-1:0]    w_ma, w_mb;
    logic [MANT_W:0]      w_sa, w_sb, w_sa_n, w_sb_n;
    logic [LZW-1:0]       w_lza, w_lzb;
    logic signed [XW-1:0] w_xa, w_xb, w_xexp;
    logic                 w_a_zero, w_b_zero, w_a_inf, w_b_inf;
    logic                 w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_sign;

    assign w_ea     = r_a[MANT_W +: EXPO_W];
    assign w_eb     = r_b[MANT_W +: EXPO_W];
    assign w_ma     = r_a[MANT_W-1:0];
    assign w_mb     = r_b[MANT_W-1:0];
    assign w_a_zero = (w_ea == '0) && (w_ma == '0);
    assign w_b_zero = (w_eb == '0) && (w_mb == '0);
    assign w_a_inf  = (&w_ea) && (w_ma == '0);
    assign w_b_inf  = (&w_eb) && (w_mb == '0);
    assign w_a_nan  = (&w_ea) && (w_ma != '0);
    assign w_b_nan  = (&w_eb) && (w_mb != '0);
    assign w_a_snan = w_a_nan && !w_ma[MANT_W-1];
    assign w_b_snan = w_b_nan && !w_mb[MANT_W-1];
    assign w_sign   = r_a[W-1] ^ r_b[W-1];
    assign w_sa     = {(w_ea != '0), w_ma};
    assign w_sb     = {(w_eb != '0), w_mb};
    assign w_lza    = f_lzc(w_sa);
    assign w_lzb    = f_lzc(w_sb);
    assign w_sa_n   = w_sa << w_lza;
    assign w_sb_n   = w_sb << w_lzb;
    assign w_xa     = (w_ea == '0) ? (XW'(1) - XW'(w_lza)) : XW'(w_ea);
    assign w_xb     = (w_eb == '0) ? (XW'(1) - XW'(w_lzb)) : XW'(w_eb);
    assign w_xexp   = w_xa - w_xb + BIAS;

    logic [W-1:0] w_qnan, w_inf, w_zero, w_spec_res;
    logic [4:0]   w_spec_st;
    logic         w_spec;

    assign w_qnan = {{SIGN_W{1'b0}}, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    assign w_inf  = {{SIGN_W{w_sign}}, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
    assign w_zero = {{SIGN_W{w_sign}}, {(EXPO_W+MANT_W){1'b0}}};

    always_comb begin
        w_spec     = 1'b1;
        w_spec_res = w_qnan;
        w_spec_st  = 5'b00000;
        if (w_a_nan || w_b_nan) begin
            w_spec_st = {(w_a_snan || w_b_snan), 4'b0000};
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_st = 5'b10000;
        end else if (w_a_inf) begin
            w_spec_res = w_inf;
        end else if (w_b_zero) begin
            w_spec_res = w_inf;
            w_spec_st  = 5'b01000;
        end else if (w_b_inf || w_a_zero) begin
            w_spec_res = w_zero;
        end else begin
            w_spec = 1'b0;
        end
    end

    // One restoring-division step
    logic            w_qbit;
    logic [MANT_W:0] w_diff, w_rem_nxt;

    assign w_qbit    = (r_rem >= {1'b0, r_div});
    assign w_diff    = r_rem[MANT_W:0] - r_div;
    assign w_rem_nxt = w_qbit ? w_diff : r_rem[MANT_W:0];

    // Normalise and, for tiny results, shift right into the subnormal range
    logic [QW-1:0]        w_qn, w_qd, w_lost;
    logic signed [XW-1:0] w_en;
    logic [XW-1:0]        w_sh, w_sh_c;
    logic                 w_tiny;

    assign w_qn   = r_q[QW-1] ? r_q : {r_q[QW-2:0], 1'b0};
    assign w_en   = r_q[QW-1] ? r_exp : (r_exp - XW'(1));
    assign w_tiny = (w_en <= 0);
    assign w_sh   = XW'(1) - w_en;
    assign w_sh_c = (w_sh > XW'(QW)) ? XW'(QW) : w_sh;
    assign {w_qd, w_lost} = {w_qn, {QW{1'b0}}} >> w_sh_c;

    // Rounding: exponent and fraction are added as one word so mantissa carry bumps the exponent
    logic                     w_g, w_r, w_lsb, w_inx, w_inc, w_of, w_uf;
    logic [XW+MANT_W-1:0]     w_sum;
    logic signed [XW-1:0]     w_rexp;
    logic [W-1:0]             w_r_inf, w_r_max, w_of_res, w_rnd_res;

    assign w_g     = r_q[1];
    assign w_r     = r_q[0];
    assign w_lsb   = r_q[2];
    assign w_inx   = w_g | w_r | r_stk;
    assign w_sum   = {r_exp, r_q[QW-2:2]} + (XW+MANT_W)'(w_inc);
    assign w_rexp  = w_sum[XW+MANT_W-1 -: XW];
    assign w_of    = (w_rexp >= EMAX);
    assign w_uf    = !w_of && (w_rexp == '0) && w_inx;
    assign w_r_inf = {{SIGN_W{r_sign}}, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
    assign w_r_max = {{SIGN_W{r_sign}}, {(EXPO_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};

    always_comb begin
        w_inc    = 1'b0;
        w_of_res = w_r_inf;
        case (r_rnd)
            2'b00: begin w_inc = w_g & (w_r | r_stk | w_lsb); w_of_res = w_r_inf; end
            2'b01: begin w_inc = 1'b0;                         w_of_res = w_r_max; end
            2'b10: begin w_inc = r_sign & w_inx;               w_of_res = r_sign ? w_r_inf : w_r_max; end
            default: begin w_inc = !r_sign & w_inx;            w_of_res = r_sign ? w_r_max : w_r_inf; end
        endcase
    end

    assign w_rnd_res = w_of ? w_of_res
                            : {{SIGN_W{r_sign}}, w_rexp[EXPO_W-1:0], w_sum[MANT_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_status    <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rnd       <= '0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_q         <= '0;
            r_stk       <= 1'b0;
            r_phase     <= 1'b0;
            r_spec      <= 1'b0;
            r_spec_res  <= '0;
            r_spec_st   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_rnd      <= bus.rnd;
                        r_in_ready <= 1'b0;
                        r_state    <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_sign     <= w_sign;
                    r_exp      <= w_xexp;
                    r_rem      <= {1'b0, w_sa_n};
                    r_div      <= w_sb_n;
                    r_q        <= '0;
                    r_cnt      <= '0;
                    r_spec     <= w_spec;
                    r_spec_res <= w_spec_res;
                    r_spec_st  <= w_spec_st;
                    r_state    <= S_DIV;
                end
                S_DIV: begin
                    r_rem <= {w_rem_nxt, 1'b0};
                    r_q   <= {r_q[QW-2:0], w_qbit};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_phase <= 1'b0;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    // Two steps: normalise/denormalise, then round and pack
                    if (!r_phase) begin
                        r_q     <= w_tiny ? w_qd : w_qn;
                        r_exp   <= w_tiny ? '0 : w_en;
                        r_stk   <= (|r_rem) | (w_tiny & (|w_lost));
                        r_phase <= 1'b1;
                    end else begin
                        r_res       <= r_spec ? r_spec_res : w_rnd_res;
                        r_status    <= r_spec ? r_spec_st
                                              : {2'b00, w_of, w_uf, (w_inx | w_of)};
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.res       = r_res;
    assign bus.status    = r_status;
endmodule

// File: tb/tb_div_iter_top.sv
// Directed-vector bench for div_iter_top (binary32): results, flags, latency, stall and reset behaviour.
module tb_div_iter_top;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rnd;
        logic [31:0] res;
        logic [4:0]  st;
    } vec_t;

    div_iter_top_if #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23)) bus ();

    div_iter_top #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation, wait for the result, then take it with a one-cycle out_ready pulse
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] ir,
                         output logic [31:0] ores, output logic [4:0] ost, output int olat);
        @(negedge clk);
        bus.a        = ia;
        bus.b        = ib;
        bus.rnd      = ir;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        olat = 0;
        while (!bus.out_valid && olat < 200) begin
            @(posedge clk);
            #1;
            olat++;
        end
        ores = bus.res;
        ost  = bus.status;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.rnd       = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_chk++; if (bus.res !== 32'h0) $display("FAIL reset res: got %h want 00000000", bus.res); else n_pass++;
        n_chk++; if (bus.status !== 5'b0) $display("FAIL reset status: got %b want 00000", bus.status); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_table(input string tag, input vec_t v[], input int n);
        logic [31:0] r;
        logic [4:0]  s;
        int          lat;
        for (int i = 0; i < n; i++) begin
            do_op(v[i].a, v[i].b, v[i].rnd, r, s, lat);
            n_chk++; if (r !== v[i].res) $display("FAIL %s[%0d] res: got %h want %h", tag, i, r, v[i].res); else n_pass++;
            n_chk++; if (s !== v[i].st) $display("FAIL %s[%0d] status: got %b want %b", tag, i, s, v[i].st); else n_pass++;
            n_chk++; if (lat !== 29) $display("FAIL %s[%0d] latency: got %0d want 29", tag, i, lat); else n_pass++;
        end
    endtask

    task automatic test_rounding();
        vec_t v[];
        v = new[7];
        v[0] = '{32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000};
        v[1] = '{32'h3F800000, 32'h40400000, 2'd0, 32'h3EAAAAAB, 5'b00001};
        v[2] = '{32'h3F800000, 32'h40400000, 2'd1, 32'h3EAAAAAA, 5'b00001};
        v[3] = '{32'h3F800000, 32'h40400000, 2'd2, 32'h3EAAAAAA, 5'b00001};
        v[4] = '{32'hBF800000, 32'h40400000, 2'd2, 32'hBEAAAAAB, 5'b00001};
        v[5] = '{32'hBF800000, 32'h40400000, 2'd3, 32'hBEAAAAAA, 5'b00001};
        v[6] = '{32'hC0C00000, 32'h40000000, 2'd0, 32'hC0400000, 5'b00000};
        run_table("round", v, 7);
    endtask

    task automatic test_specials();
        vec_t v[];
        v = new[9];
        v[0] = '{32'h3F800000, 32'h00000000, 2'd0, 32'h7F800000, 5'b01000};
        v[1] = '{32'h00000000, 32'h00000000, 2'd0, 32'h7FC00000, 5'b10000};
        v[2] = '{32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 5'b10000};
        v[3] = '{32'h7FC00000, 32'h3F800000, 2'd0, 32'h7FC00000, 5'b00000};
        v[4] = '{32'h7F800000, 32'hFF800000, 2'd0, 32'h7FC00000, 5'b10000};
        v[5] = '{32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 5'b00000};
        v[6] = '{32'h40000000, 32'hFF800000, 2'd0, 32'h80000000, 5'b00000};
        v[7] = '{32'h80000000, 32'h40000000, 2'd0, 32'h80000000, 5'b00000};
        v[8] = '{32'hBF800000, 32'h00000000, 2'd0, 32'hFF800000, 5'b01000};
        run_table("special", v, 9);
    endtask

    task automatic test_overflow();
        vec_t v[];
        v = new[6];
        v[0] = '{32'h7F7FFFFF, 32'h00000001, 2'd0, 32'h7F800000, 5'b00101};
        v[1] = '{32'h7F7FFFFF, 32'h00000001, 2'd1, 32'h7F7FFFFF, 5'b00101};
        v[2] = '{32'h7F7FFFFF, 32'h00000001, 2'd2, 32'h7F7FFFFF, 5'b00101};
        v[3] = '{32'h7F7FFFFF, 32'h00000001, 2'd3, 32'h7F800000, 5'b00101};
        v[4] = '{32'hFF7FFFFF, 32'h00000001, 2'd2, 32'hFF800000, 5'b00101};
        v[5] = '{32'hFF7FFFFF, 32'h00000001, 2'd3, 32'hFF7FFFFF, 5'b00101};
        run_table("ovf", v, 6);
    endtask

    task automatic test_subnormal();
        vec_t v[];
        v = new[4];
        v[0] = '{32'h00800000, 32'h40000000, 2'd0, 32'h00400000, 5'b00000};
        v[1] = '{32'h00000001, 32'h40000000, 2'd0, 32'h00000000, 5'b00011};
        v[2] = '{32'h00000001, 32'h40000000, 2'd3, 32'h00000001, 5'b00011};
        v[3] = '{32'h00400000, 32'h3F000000, 2'd0, 32'h00800000, 5'b00000};
        run_table("subn", v, 4);
    endtask

    task automatic test_stall();
        int waited;
        @(negedge clk);
        bus.a        = 32'h40C00000;
        bus.b        = 32'h40000000;
        bus.rnd      = 2'd0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Keep presenting a different operand while busy; it must be ignored
        bus.a = 32'h3F800000;
        bus.b = 32'h40400000;
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL stall busy in_ready: got %b want 0", bus.in_ready); else n_pass++;
        waited = 0;
        while (!bus.out_valid && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_chk++; if (waited !== 29) $display("FAIL stall latency: got %0d want 29", waited); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            n_chk++; if (bus.res !== 32'h40400000) $display("FAIL stall res cycle %0d: got %h want 40400000", c, bus.res); else n_pass++;
            n_chk++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
                $display("FAIL stall hs cycle %0d: got in_ready=%b out_valid=%b want 0/1", c, bus.in_ready, bus.out_valid);
            else n_pass++;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL stall release: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic [4:0]  s;
        int          lat;
        int          seen;
        @(negedge clk);
        bus.a        = 32'h3F800000;
        bus.b        = 32'h40400000;
        bus.rnd      = 2'd0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_chk++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL midrst state: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        else n_pass++;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        bus.out_ready = 1'b0;
        n_chk++; if (seen !== 0) $display("FAIL midrst no result: got %0d valid cycles want 0", seen); else n_pass++;
        do_op(32'h40C00000, 32'h40000000, 2'd0, r, s, lat);
        n_chk++; if (r !== 32'h40400000 || s !== 5'b0)
            $display("FAIL midrst recovery: got %h/%b want 40400000/00000", r, s);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [4:0]  s;
        int          lat;
        do_op(32'h3F800000, 32'h40400000, 2'd1, r, s, lat);
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL b2b in_ready after take: got %b want 1", bus.in_ready); else n_pass++;
        n_chk++; if (r !== 32'h3EAAAAAA) $display("FAIL b2b first res: got %h want 3EAAAAAA", r); else n_pass++;
        do_op(32'h40C00000, 32'h40000000, 2'd0, r, s, lat);
        n_chk++; if (r !== 32'h40400000 || s !== 5'b0)
            $display("FAIL b2b second: got %h/%b want 40400000/00000", r, s);
        else n_pass++;
        n_chk++; if (lat !== 29) $display("FAIL b2b latency: got %0d want 29", lat); else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_rounding();
        test_specials();
        test_overflow();
        test_subnormal();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
